// File: rtl/beat_generator.sv
// Metronome beat timing: turns an 8-bit BPM into a beat period with a bit-serial
// restoring divider, then runs a period counter that emits beat, click, downbeat and bar index.
module beat_generator #(
  parameter int unsigned CLK_HZ        = 50000000,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned BEATS_PER_BAR = 4,
  parameter int unsigned CLICK_CYCLES  = 2500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       bpm,
  input  logic             enable,
  output logic             beat,
  output logic             click,
  output logic             downbeat,
  output logic [3:0]       beat_idx,
  output logic [CNT_W-1:0] period,
  output logic             div_busy
);

  localparam logic [63:0]          NUM_64     = 64'(CLK_HZ) * 64'd60;
  localparam logic [CNT_W-1:0]     NUM        = NUM_64[CNT_W-1:0];
  localparam int unsigned          STEP_W     = (CNT_W > 1) ? $clog2(CNT_W) : 1;
  localparam logic [STEP_W-1:0]    LAST_STEP  = STEP_W'(CNT_W - 1);
  localparam int unsigned          CLICK_W    = (CLICK_CYCLES > 1) ? $clog2(CLICK_CYCLES) : 1;
  localparam logic [CLICK_W-1:0]   CLICK_LOAD = CLICK_W'(CLICK_CYCLES - 1);
  localparam logic [3:0]           LAST_IDX   = 4'(BEATS_PER_BAR - 1);

  typedef enum logic {
    DIV_IDLE = 1'b0,
    DIV_RUN  = 1'b1
  } div_state_e;

  div_state_e         div_state_q, div_state_d;
  logic [7:0]         bpm_q, bpm_d;
  logic [7:0]         rem_q, rem_d;
  logic [CNT_W-1:0]   dvd_q, dvd_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]         idx_q, idx_d;
  logic [CLICK_W-1:0] click_q, click_d;

  logic [7:0]         d_eff;
  logic               div_start;
  logic [8:0]         trial;
  logic [8:0]         diff;
  logic               fits;
  logic [CNT_W-1:0]   dvd_shift;
  logic               run;
  logic               beat_w;

  always_comb begin
    d_eff       = (bpm == 8'd0) ? 8'd1 : bpm;
    // bpm_q resets to 0 and d_eff is never 0, so the first cycle after reset always starts a division.
    div_start   = (d_eff != bpm_q);
    trial       = {rem_q, dvd_q[CNT_W-1]};
    diff        = trial - {1'b0, bpm_q};
    fits        = (trial >= {1'b0, bpm_q});
    dvd_shift   = {dvd_q[CNT_W-2:0], fits};

    bpm_d       = d_eff;
    div_state_d = div_state_q;
    rem_d       = rem_q;
    dvd_d       = dvd_q;
    step_d      = step_q;
    period_d    = period_q;

    // A new divisor abandons any division in flight; period is only written on the last step.
    if (div_start) begin
      div_state_d = DIV_RUN;
      rem_d       = '0;
      dvd_d       = NUM;
      step_d      = '0;
    end else if (div_state_q == DIV_RUN) begin
      rem_d  = fits ? diff[7:0] : trial[7:0];
      dvd_d  = dvd_shift;
      step_d = step_q + 1'b1;
      if (step_q == LAST_STEP) begin
        div_state_d = DIV_IDLE;
        period_d    = dvd_shift;
      end
    end

    run    = enable && (period_q != '0);
    beat_w = !rst && run && (cnt_q >= (period_q - 1'b1));

    cnt_d = cnt_q;
    idx_d = idx_q;
    if (!run) begin
      cnt_d = '1;
      idx_d = 4'd0;
    end else if (beat_w) begin
      cnt_d = '0;
      idx_d = (idx_q == LAST_IDX) ? 4'd0 : idx_q + 4'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // The beat cycle itself counts as the first click cycle, hence the load of CLICK_CYCLES-1.
    if (beat_w) begin
      click_d = CLICK_LOAD;
    end else if (click_q != '0) begin
      click_d = click_q - 1'b1;
    end else begin
      click_d = click_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_state_q <= DIV_IDLE;
      bpm_q       <= '0;
      rem_q       <= '0;
      dvd_q       <= '0;
      step_q      <= '0;
      period_q    <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      click_q     <= '0;
    end else begin
      div_state_q <= div_state_d;
      bpm_q       <= bpm_d;
      rem_q       <= rem_d;
      dvd_q       <= dvd_d;
      step_q      <= step_d;
      period_q    <= period_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      click_q     <= click_d;
    end
  end

  assign beat     = beat_w;
  assign downbeat = beat_w && (idx_q == 4'd0);
  assign click    = beat_w || (click_q != '0);
  assign beat_idx = idx_q;
  assign period   = period_q;
  assign div_busy = (div_state_q == DIV_RUN);

endmodule
